// File: rtl/adder4_bist.sv
// rtl/adder4_bist.sv - built-in self test sweeping every operand pair through a 4-bit adder under test.
// Optional macro ADDER4_BIST_DIRECTED_EN prepends two directed vectors (14,14) and (2,8) to the sweep.
module adder4_bist #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [3:0] dut_a,
    output logic [3:0] dut_b,
    input  logic [3:0] dut_sum,
    input  logic       dut_carryout,
    input  logic       dut_overflow,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic       fail_valid,
    output logic [3:0] fail_a,
    output logic [3:0] fail_b
);

`ifdef ADDER4_BIST_DIRECTED_EN
    localparam int IDX_W = 9;
    localparam logic [IDX_W-1:0] LAST_IDX = 9'd257;
`else
    localparam int IDX_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = 8'd255;
`endif
    localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       settle_q, settle_d;
    logic [3:0]       dut_a_q, dut_a_d, dut_b_q, dut_b_d;
    logic [8:0]       err_q, err_d;
    logic             fail_valid_q, fail_valid_d;
    logic [3:0]       fail_a_q, fail_a_d, fail_b_q, fail_b_d;

    logic [3:0] vec_a, vec_b;
    logic [4:0] exp_full;
    logic       exp_ovf;
    logic       mismatch;
    logic       busy_w;

    always_comb begin
`ifdef ADDER4_BIST_DIRECTED_EN
        logic [7:0] sweep_idx;
        sweep_idx = idx_q[7:0] - 8'd2;
        if (idx_q == 9'd0) begin
            vec_a = 4'd14;
            vec_b = 4'd14;
        end else if (idx_q == 9'd1) begin
            vec_a = 4'd2;
            vec_b = 4'd8;
        end else begin
            vec_a = sweep_idx[7:4];
            vec_b = sweep_idx[3:0];
        end
`else
        vec_a = idx_q[7:4];
        vec_b = idx_q[3:0];
`endif
    end

    // Reference results come from the registered operands the adder is currently seeing.
    always_comb begin
        exp_full = {1'b0, dut_a_q} + {1'b0, dut_b_q};
        exp_ovf  = (dut_a_q[3] == dut_b_q[3]) && (exp_full[3] != dut_a_q[3]);
        mismatch = (dut_sum != exp_full[3:0]) || (dut_carryout != exp_full[4]) ||
                   (dut_overflow != exp_ovf);
    end

    assign busy_w = (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        settle_d     = settle_q;
        dut_a_d      = dut_a_q;
        dut_b_d      = dut_b_q;
        err_d        = err_q;
        fail_valid_d = fail_valid_q;
        fail_a_d     = fail_a_q;
        fail_b_d     = fail_b_q;
        if (abort && (busy_w || state_q == S_DONE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d      = S_APPLY;
                        idx_d        = '0;
                        err_d        = '0;
                        fail_valid_d = 1'b0;
                        fail_a_d     = '0;
                        fail_b_d     = '0;
                    end
                end
                S_APPLY: begin
                    dut_a_d  = vec_a;
                    dut_b_d  = vec_b;
                    settle_d = '0;
                    state_d  = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        err_d = err_q + 9'd1;
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            fail_a_d     = dut_a_q;
                            fail_b_d     = dut_b_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_APPLY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            settle_q     <= '0;
            dut_a_q      <= '0;
            dut_b_q      <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            dut_a_q      <= dut_a_d;
            dut_b_q      <= dut_b_d;
            err_q        <= err_d;
            fail_valid_q <= fail_valid_d;
            fail_a_q     <= fail_a_d;
            fail_b_q     <= fail_b_d;
        end
    end

    assign dut_a      = dut_a_q;
    assign dut_b      = dut_b_q;
    assign busy       = busy_w;
    assign done       = (state_q == S_DONE);
    assign pass       = (state_q == S_DONE) && (err_q == 9'd0);
    assign err_count  = err_q;
    assign fail_valid = fail_valid_q;
    assign fail_a     = fail_a_q;
    assign fail_b     = fail_b_q;

endmodule
